simple_cpu_ctrl: RTL and testbench

Multi-cycle instruction sequencer that sits directly upstream of the 16-bit CPU datapath (register file + 74181-style ALU), driving all of the datapath's control ports. Each instruction runs as follows:
- Fetch a 32-bit instruction from a synchronous program memory.
- Decode it into register addresses, ALU controls and the immediate.
- Capture the datapath result and write it back to the register file.
The block also maintains PC, Z/C flags and a retired-instruction counter.

---
 rtl/simple_cpu_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_simple_cpu_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_cpu_ctrl.sv
// Multi-cycle sequencer for the 16-bit CPU datapath: fetch, decode, execute and
// write back one instruction at a time, keeping PC, Z/C flags and a retired count.
module simple_cpu_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int PC_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic [31:0]           imem_data,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_cout,
  output logic [ADDR_WIDTH-1:0] reg_read_addr1,
  output logic [ADDR_WIDTH-1:0] reg_read_addr2,
  output logic                  reg_write_enable,
  output logic [ADDR_WIDTH-1:0] reg_write_addr,
  output logic [DATA_WIDTH-1:0] reg_write_data,
  output logic                  alu_cin,
  output logic                  alu_mode,
  output logic [3:0]            alu_comm,
  output logic                  b_source_sel,
  output logic [DATA_WIDTH-1:0] alu_b_imm,
  output logic                  busy,
  output logic                  halted,
  output logic                  flag_z,
  output logic                  flag_c,
  output logic [15:0]           instr_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;

  localparam logic [2:0] OP_ALU_RR = 3'b000;
  localparam logic [2:0] OP_ALU_RI = 3'b001;
  localparam logic [2:0] OP_LDI    = 3'b010;
  localparam logic [2:0] OP_NOP    = 3'b011;
  localparam logic [2:0] OP_HALT   = 3'b100;
  localparam logic [2:0] OP_JMP    = 3'b101;
  localparam logic [2:0] OP_JZ     = 3'b110;
  localparam logic [2:0] OP_JC     = 3'b111;

  logic [2:0]            state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [31:0]           ir_q, ir_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  carry_tmp_q, carry_tmp_d;
  logic                  flag_z_q, flag_z_d;
  logic                  flag_c_q, flag_c_d;
  logic                  halted_q, halted_d;
  logic [15:0]           count_q, count_d;

  logic [2:0]            op_s;
  logic [PC_WIDTH-1:0]   pc_inc_s;
  logic [PC_WIDTH-1:0]   target_s;
  logic                  is_alu_s;
  logic                  unused_ir_bit_s;

  assign op_s            = ir_q[31:29];
  assign pc_inc_s        = pc_q + PC_WIDTH'(1);
  assign target_s        = ir_q[PC_WIDTH-1:0];
  assign is_alu_s        = (op_s == OP_ALU_RR) || (op_s == OP_ALU_RI);
  assign unused_ir_bit_s = ir_q[16];

  // Datapath controls are pure decodes of IR so they hold steady from EXEC through WB.
  assign alu_cin          = ir_q[28];
  assign alu_mode         = ir_q[27];
  assign alu_comm         = ir_q[26:23];
  assign reg_write_addr   = ir_q[22:20];
  assign reg_read_addr1   = ir_q[19:17];
  assign reg_read_addr2   = ir_q[ADDR_WIDTH-1:0];
  assign alu_b_imm        = ir_q[DATA_WIDTH-1:0];
  assign b_source_sel     = (op_s == OP_ALU_RI);
  assign reg_write_data   = result_q;
  // A reset landing on the WB cycle must suppress the write that cycle.
  assign reg_write_enable = (state_q == S_WB) && !reset;
  assign imem_addr        = pc_q;
  assign busy             = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                            (state_q == S_EXEC)  || (state_q == S_WB);
  assign halted           = halted_q;
  assign flag_z           = flag_z_q;
  assign flag_c           = flag_c_q;
  assign instr_count      = count_q;

  // Next-state and datapath-register update for the instruction sequencer.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    result_d    = result_q;
    carry_tmp_d = carry_tmp_q;
    flag_z_d    = flag_z_q;
    flag_c_d    = flag_c_q;
    halted_d    = halted_q;
    count_d     = count_q;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d  = S_FETCH;
          halted_d = 1'b0;
        end else begin
          state_d  = state_q;
        end
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = imem_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op_s)
          OP_ALU_RR, OP_ALU_RI: begin
            result_d    = alu_result;
            carry_tmp_d = alu_cout;
            state_d     = S_WB;
          end
          OP_LDI: begin
            result_d = ir_q[DATA_WIDTH-1:0];
            state_d  = S_WB;
          end
          OP_HALT: begin
            pc_d     = pc_inc_s;
            halted_d = 1'b1;
            count_d  = count_q + 16'd1;
            state_d  = S_HALTED;
          end
          OP_JMP: begin
            pc_d    = target_s;
            count_d = count_q + 16'd1;
            state_d = S_FETCH;
          end
          OP_JZ: begin
            pc_d    = flag_z_q ? target_s : pc_inc_s;
            count_d = count_q + 16'd1;
            state_d = S_FETCH;
          end
          OP_JC: begin
            pc_d    = flag_c_q ? target_s : pc_inc_s;
            count_d = count_q + 16'd1;
            state_d = S_FETCH;
          end
          default: begin
            pc_d    = pc_inc_s;
            count_d = count_q + 16'd1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_WB: begin
        pc_d    = pc_inc_s;
        count_d = count_q + 16'd1;
        state_d = S_FETCH;
        // LDI writes a register but leaves the flags alone.
        if (is_alu_s) begin
          flag_z_d = (result_q == {DATA_WIDTH{1'b0}});
          flag_c_d = carry_tmp_q;
        end else begin
          flag_z_d = flag_z_q;
          flag_c_d = flag_c_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= {PC_WIDTH{1'b0}};
      ir_q        <= 32'd0;
      result_q    <= {DATA_WIDTH{1'b0}};
      carry_tmp_q <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      halted_q    <= 1'b0;
      count_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      result_q    <= result_d;
      carry_tmp_q <= carry_tmp_d;
      flag_z_q    <= flag_z_d;
      flag_c_q    <= flag_c_d;
      halted_q    <= halted_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_simple_cpu_ctrl.sv
// Directed bench for simple_cpu_ctrl: synchronous program memory, a fixed-value
// ALU stand-in, and hand-computed expectations at every observation point.
module tb_simple_cpu_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic [15:0] alu_result;
  logic        alu_cout;
  logic [2:0]  reg_read_addr1;
  logic [2:0]  reg_read_addr2;
  logic        reg_write_enable;
  logic [2:0]  reg_write_addr;
  logic [15:0] reg_write_data;
  logic        alu_cin;
  logic        alu_mode;
  logic [3:0]  alu_comm;
  logic        b_source_sel;
  logic [15:0] alu_b_imm;
  logic        busy;
  logic        halted;
  logic        flag_z;
  logic        flag_c;
  logic [15:0] instr_count;

  logic [31:0] mem [0:255];
  int n_cmp;
  int n_err;

  simple_cpu_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .imem_addr        (imem_addr),
    .imem_data        (imem_data),
    .alu_result       (alu_result),
    .alu_cout         (alu_cout),
    .reg_read_addr1   (reg_read_addr1),
    .reg_read_addr2   (reg_read_addr2),
    .reg_write_enable (reg_write_enable),
    .reg_write_addr   (reg_write_addr),
    .reg_write_data   (reg_write_data),
    .alu_cin          (alu_cin),
    .alu_mode         (alu_mode),
    .alu_comm         (alu_comm),
    .b_source_sel     (b_source_sel),
    .alu_b_imm        (alu_b_imm),
    .busy             (busy),
    .halted           (halted),
    .flag_z           (flag_z),
    .flag_c           (flag_c),
    .instr_count      (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program memory: data follows the address by one cycle.
  always @(posedge clk) imem_data <= mem[imem_addr];

  function automatic logic [31:0] mk(input logic [2:0] op, input logic cin, input logic mode,
                                     input logic [3:0] comm, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [15:0] imm);
    return {op, cin, mode, comm, rd, rs1, 1'b0, imm};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  logic [2:0]  t2_addr [3];
  logic [15:0] t2_data [3];

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    start = 1'b0;
    alu_result = 16'h0000;
    alu_cout = 1'b0;
    imem_data = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = mk(3'b011, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0, 16'h0000);
    t2_addr = '{3'd1, 3'd2, 3'd3};
    t2_data = '{16'h0005, 16'h0003, 16'h0008};

    // Power-on reset
    tick(2);
    reset = 1'b0;
    check("por_imem_addr", 32'(imem_addr), 32'h0);
    check("por_busy", 32'(busy), 32'h0);
    check("por_misc_zero", 32'(|{reg_read_addr1, reg_read_addr2, reg_write_enable, reg_write_addr,
                                  reg_write_data, alu_cin, alu_mode, alu_comm, b_source_sel,
                                  alu_b_imm, halted, flag_z, flag_c, instr_count}), 32'h0);

    // Test 2: LDI, LDI, ALU_RR, HALT
    mem[0] = mk(3'b010, 1'b0, 1'b0, 4'd0, 3'd1, 3'd0, 16'h0005);
    mem[1] = mk(3'b010, 1'b0, 1'b0, 4'd0, 3'd2, 3'd0, 16'h0003);
    mem[2] = mk(3'b000, 1'b0, 1'b0, 4'b1001, 3'd3, 3'd1, 16'h0002);
    mem[3] = mk(3'b100, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0, 16'h0000);
    alu_result = 16'h0008;
    alu_cout = 1'b0;
    pulse_start();
    for (int c = 1; c <= 15; c++) begin
      check("t2_we", 32'(reg_write_enable), 32'((c % 4) == 0));
      if ((c % 4) == 0) begin
        check("t2_waddr", 32'(reg_write_addr), 32'(t2_addr[c/4 - 1]));
        check("t2_wdata", 32'(reg_write_data), 32'(t2_data[c/4 - 1]));
      end
      if (c == 1) check("t2_first_fetch", 32'(imem_addr), 32'h0);
      if (c == 11) begin
        check("t2_rs1", 32'(reg_read_addr1), 32'd1);
        check("t2_rs2", 32'(reg_read_addr2), 32'd2);
        check("t2_bsel", 32'(b_source_sel), 32'd0);
      end
      tick(1);
    end
    check("t2_halted", 32'(halted), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_count", 32'(instr_count), 32'd4);
    check("t2_pc", 32'(imem_addr), 32'd4);
    check("t2_flags", 32'({flag_z, flag_c}), 32'd0);

    // Test 1: reset held 2 cycles with state already built up
    reset = 1'b1;
    tick(1);
    check("t1_we_in_reset", 32'(reg_write_enable), 32'd0);
    tick(1);
    reset = 1'b0;
    check("t1_imem_addr", 32'(imem_addr), 32'h0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_halted", 32'(halted), 32'd0);
    check("t1_count", 32'(instr_count), 32'd0);
    check("t1_misc_zero", 32'(|{reg_read_addr1, reg_read_addr2, reg_write_enable, reg_write_addr,
                                 reg_write_data, alu_cin, alu_mode, alu_comm, b_source_sel,
                                 alu_b_imm, flag_z, flag_c}), 32'h0);

    // Test 3 and 4: ALU_RI setting Z/C, JZ taken, ALU_RR clearing flags, JC not taken, JMP wrap
    mem[0]     = mk(3'b001, 1'b1, 1'b0, 4'b0110, 3'd4, 3'd1, 16'hFFFF);
    mem[1]     = mk(3'b110, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0, 16'h0010);
    mem[8'h10] = mk(3'b000, 1'b0, 1'b0, 4'b1001, 3'd5, 3'd2, 16'h0003);
    mem[8'h11] = mk(3'b111, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0, 16'h0020);
    mem[8'h12] = mk(3'b101, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0, 16'h00FF);
    mem[8'hFF] = mk(3'b011, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0, 16'h0000);
    alu_result = 16'h0000;
    alu_cout = 1'b1;
    pulse_start();
    tick(2);
    check("t3_bsel", 32'(b_source_sel), 32'd1);
    check("t3_imm", 32'(alu_b_imm), 32'hFFFF);
    check("t3_ctl", 32'({alu_cin, alu_mode, alu_comm}), 32'({1'b1, 1'b0, 4'b0110}));
    check("t3_rs", 32'({reg_read_addr1, reg_read_addr2}), 32'({3'd1, 3'd7}));
    tick(1);
    check("t3_we", 32'(reg_write_enable), 32'd1);
    check("t3_wb", 32'({reg_write_addr, reg_write_data}), 32'({3'd4, 16'h0000}));
    tick(1);
    check("t3_flags", 32'({flag_z, flag_c}), 32'b11);
    check("t3_pc", 32'(imem_addr), 32'h01);
    tick(3);
    check("t3_jz_target", 32'(imem_addr), 32'h10);
    check("t3_count", 32'(instr_count), 32'd2);
    alu_result = 16'h0001;
    alu_cout = 1'b0;
    tick(3);
    check("t4_we", 32'(reg_write_enable), 32'd1);
    check("t4_wb", 32'({reg_write_addr, reg_write_data}), 32'({3'd5, 16'h0001}));
    tick(1);
    check("t4_flags", 32'({flag_z, flag_c}), 32'b00);
    check("t4_pc_jc", 32'(imem_addr), 32'h11);
    tick(3);
    check("t4_jc_fallthru", 32'(imem_addr), 32'h12);
    tick(3);
    check("t4_jmp_ff", 32'(imem_addr), 32'hFF);
    tick(3);
    check("t4_pc_wrap", 32'(imem_addr), 32'h00);
    check("t4_count", 32'(instr_count), 32'd6);

    // Test 5: start during EXEC ignored, resume after HALT
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    mem[0] = mk(3'b010, 1'b0, 1'b0, 4'd0, 3'd6, 3'd0, 16'h00AA);
    for (int i = 1; i <= 6; i++) mem[i] = mk(3'b011, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0, 16'h0000);
    mem[7] = mk(3'b100, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0, 16'h0000);
    mem[8] = mk(3'b010, 1'b0, 1'b0, 4'd0, 3'd6, 3'd0, 16'h1234);
    mem[9] = mk(3'b100, 1'b0, 1'b0, 4'd0, 3'd0, 3'd0, 16'h0000);
    pulse_start();
    tick(2);
    pulse_start();
    check("t5_start_ignored_we", 32'(reg_write_enable), 32'd1);
    check("t5_start_ignored_data", 32'(reg_write_data), 32'h00AA);
    check("t5_start_ignored_pc", 32'(imem_addr), 32'h0);
    tick(22);
    check("t5_halted", 32'(halted), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_count", 32'(instr_count), 32'd8);
    check("t5_pc", 32'(imem_addr), 32'd8);
    tick(2);
    check("t5_hold_halted", 32'({halted, busy}), 32'b10);
    pulse_start();
    check("t5_resume_pc", 32'(imem_addr), 32'd8);
    check("t5_resume_state", 32'({halted, busy}), 32'b01);
    tick(3);
    check("t5_resume_wb", 32'({reg_write_enable, reg_write_addr, reg_write_data}),
          32'({1'b1, 3'd6, 16'h1234}));
    tick(4);
    check("t5_halted2", 32'(halted), 32'd1);
    check("t5_count2", 32'(instr_count), 32'd10);
    check("t5_pc2", 32'(imem_addr), 32'd10);

    // Test 6: reset landing on the WB cycle
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    mem[0] = mk(3'b010, 1'b0, 1'b0, 4'd0, 3'd7, 3'd0, 16'h5555);
    pulse_start();
    tick(3);
    check("t6_we_before", 32'(reg_write_enable), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_we_suppressed", 32'(reg_write_enable), 32'd0);
    tick(1);
    check("t6_idle", 32'({busy, halted, reg_write_enable}), 32'd0);
    check("t6_pc", 32'(imem_addr), 32'h0);
    check("t6_count", 32'(instr_count), 32'd0);
    reset = 1'b0;
    tick(1);
    check("t6_stays_idle", 32'(busy), 32'd0);
    pulse_start();
    check("t6_restart_pc", 32'(imem_addr), 32'h0);
    check("t6_restart_busy", 32'(busy), 32'd1);
    tick(3);
    check("t6_restart_wb", 32'({reg_write_enable, reg_write_addr, reg_write_data}),
          32'({1'b1, 3'd7, 16'h5555}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
